clkgen_multi: RTL and testbench

Parametrised multi-channel clock generator. It derives NUM_CH independently programmable 50%-duty divided clocks from the single system clock, plus a rising-edge tick strobe per channel. Each channel has glitch-free run-time divisor changes and low-phase clock gating. A programmable watchdog counter with kick and sticky timeout is included. Sits at the top of the SoC clocking tree and feeds the peripheral, low-speed and watchdog clock consumers.

---
 rtl/clkgen_multi.sv | 110 +++++++++++
 tb/tb_clkgen_multi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/clkgen_multi.sv
// Derives NUM_CH 50%-duty divided clocks plus rising-edge ticks; outputs are registered, no backpressure.
// Watchdog counter is present only when CLKGEN_WDT_EN is defined; otherwise wdt_count/wdt_timeout read 0.
module clkgen_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16,
  parameter int WDT_W  = 20,
  localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [NUM_CH-1:0]   ch_en,
  output logic [NUM_CH-1:0]   div_clk,
  output logic [NUM_CH-1:0]   tick,
  input  logic                wdt_en,
  input  logic                wdt_kick,
  input  logic [WDT_W-1:0]    wdt_load,
  output logic [WDT_W-1:0]    wdt_count,
  output logic                wdt_timeout
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_shd;
    logic             run;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;
    logic             start;
    logic             stop;
    logic             wrap;

    // Out-of-range cfg_ch values never match any generated index.
    assign wr_hit = cfg_we && (cfg_ch == CH_IDX_W'(i));
    assign start  = !run && ch_en[i];
    assign stop   = run && !ch_en[i] && !clk_q;
    assign wrap   = run && !stop && (cnt == div_act);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt     <= '0;
        div_act <= '0;
        div_shd <= '0;
        run     <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        if (wr_hit) begin
          div_shd <= cfg_div;
        end
        tick_q <= wrap && !clk_q;
        if (start) begin
          run     <= 1'b1;
          cnt     <= '0;
          div_act <= div_shd;
        end else if (stop) begin
          run <= 1'b0;
          cnt <= '0;
        end else if (wrap) begin
          cnt     <= '0;
          clk_q   <= ~clk_q;
          div_act <= div_shd;
          // A wrap while disabled is always the high-to-low edge, ending the drain.
          if (!ch_en[i]) begin
            run <= 1'b0;
          end
        end else if (run) begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end

    assign div_clk[i] = clk_q;
    assign tick[i]    = tick_q;

    a_tick_high : assert property (@(posedge clk) disable iff (!reset) tick_q |-> clk_q);
    a_cnt_range : assert property (@(posedge clk) disable iff (!reset) run |-> (cnt <= div_act));
  end

`ifdef CLKGEN_WDT_EN
  logic [WDT_W-1:0] wdt_cnt_q;
  logic             wdt_to_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdt_cnt_q <= '0;
      wdt_to_q  <= 1'b0;
    end else if (!wdt_en || wdt_kick) begin
      wdt_cnt_q <= wdt_load;
      wdt_to_q  <= 1'b0;
    end else if (wdt_cnt_q == '0) begin
      wdt_to_q <= 1'b1;
    end else begin
      wdt_cnt_q <= wdt_cnt_q - WDT_W'(1);
    end
  end

  assign wdt_count   = wdt_cnt_q;
  assign wdt_timeout = wdt_to_q;
`else
  logic unused_wdt;
  assign unused_wdt  = ^{wdt_en, wdt_kick, wdt_load};
  assign wdt_count   = '0;
  assign wdt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_clkgen_multi.sv
// Self-checking bench for clkgen_multi: expected toggle schedules per scenario feed a scoreboard queue.
module tb_clkgen_multi;
  localparam int NUM_CH   = 3;
  localparam int DIV_W    = 16;
  localparam int WDT_W    = 20;
  localparam int CH_IDX_W = 2;
`ifdef CLKGEN_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                cfg_we;
  logic [CH_IDX_W-1:0] cfg_ch;
  logic [DIV_W-1:0]    cfg_div;
  logic [NUM_CH-1:0]   ch_en;
  logic [NUM_CH-1:0]   div_clk;
  logic [NUM_CH-1:0]   tick;
  logic                wdt_en;
  logic                wdt_kick;
  logic [WDT_W-1:0]    wdt_load;
  logic [WDT_W-1:0]    wdt_count;
  logic                wdt_timeout;

  always #5 clk = ~clk;

  clkgen_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .WDT_W(WDT_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .ch_en(ch_en), .div_clk(div_clk), .tick(tick), .wdt_en(wdt_en), .wdt_kick(wdt_kick),
    .wdt_load(wdt_load), .wdt_count(wdt_count), .wdt_timeout(wdt_timeout)
  );

  typedef struct {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] tck;
    logic [WDT_W-1:0]  cnt;
    logic              to;
  } exp_t;

  typedef struct {
    logic             en;
    logic             kick;
    logic [WDT_W-1:0] load;
    logic [WDT_W-1:0] cnt;
    logic             to;
  } wvec_t;

  exp_t        sb[$];
  wvec_t       wt[$];
  logic [63:0] tgl [NUM_CH];  // bit k set: channel toggles on edge k after the enable edge
  int          n_chk = 0;
  int          n_pass = 0;
  int          l2_0[7] = '{2, 4, 6, 8, 12, 16, 20};
  int          l2_1[5] = '{3, 6, 11, 16, 21};
  int          l3_0[5] = '{4, 8, 17, 21, 25};
  int          l3_2[4] = '{4, 8, 21, 25};

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  task automatic clr_tgl();
    for (int c = 0; c < NUM_CH; c++) tgl[c] = '0;
  endtask

  task automatic set_periodic(input int c, input int d);
    for (int t = d + 1; t < 64; t += d + 1) tgl[c][t] = 1'b1;
  endtask

  // Push the expectation for edge k, clock the DUT, then pop and compare.
  task automatic step_chk(input int scn, input int k, input logic [WDT_W-1:0] wcnt, input logic wto);
    exp_t        e;
    logic [63:0] m;
    m = (64'd2 << k) - 64'd1;
    for (int c = 0; c < NUM_CH; c++) begin
      e.clk[c] = ^(tgl[c] & m);
      e.tck[c] = tgl[c][k] & e.clk[c];
    end
    e.cnt = WDT_ON ? wcnt : '0;
    e.to  = WDT_ON & wto;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp($sformatf("s%0d_k%0d_clk_tick", scn, k), 64'({div_clk, tick}), 64'({e.clk, e.tck}));
    cmp($sformatf("s%0d_k%0d_wdt", scn, k), 64'({wdt_count, wdt_timeout}), 64'({e.cnt, e.to}));
  endtask

  task automatic do_reset();
    reset = 1'b0; ch_en = '0; cfg_we = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [CH_IDX_W-1:0] c, input logic [DIV_W-1:0] d);
    cfg_we = 1'b1; cfg_ch = c; cfg_div = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  initial begin
    // Reset held with busy inputs: everything must read zero.
    reset = 1'b0; cfg_we = 1'b1; cfg_ch = '0; cfg_div = 16'd5; ch_en = '1;
    wdt_en = 1'b1; wdt_kick = 1'b0; wdt_load = 20'd5;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_clk_tick", 64'({div_clk, tick}), 64'd0);
    cmp("reset_wdt", 64'({wdt_count, wdt_timeout}), 64'd0);

    // S1: d=0, d=2, d=1 from a common enable; cfg_ch=3 is out of range.
    wdt_load = '0;
    do_reset();
    wr(2'd0, 16'd0); wr(2'd1, 16'd2); wr(2'd2, 16'd1); wr(2'd3, 16'd7);
    clr_tgl(); set_periodic(0, 0); set_periodic(1, 2); set_periodic(2, 1);
    ch_en = 3'b111;
    for (int k = 0; k < 14; k++) step_chk(1, k, '0, 1'b0);

    // S2: ch1 2->4 mid half-period; ch0 rewritten on its own wrap edge.
    do_reset();
    wr(2'd0, 16'd1); wr(2'd1, 16'd2);
    clr_tgl();
    foreach (l2_0[j]) tgl[0][l2_0[j]] = 1'b1;
    foreach (l2_1[j]) tgl[1][l2_1[j]] = 1'b1;
    ch_en = 3'b011;
    for (int k = 0; k < 23; k++) begin
      cfg_we = (k == 4) || (k == 6);
      cfg_ch = (k == 4) ? 2'd1 : 2'd0;
      cfg_div = (k == 4) ? 16'd4 : 16'd3;
      step_chk(2, k, '0, 1'b0);
    end
    cfg_we = 1'b0;

    // S3: gating while high (ch2), while low (ch0), and re-enable inside the drain (ch1).
    do_reset();
    wr(2'd0, 16'd3); wr(2'd1, 16'd3); wr(2'd2, 16'd3);
    clr_tgl(); set_periodic(1, 3);
    foreach (l3_0[j]) tgl[0][l3_0[j]] = 1'b1;
    foreach (l3_2[j]) tgl[2][l3_2[j]] = 1'b1;
    for (int k = 0; k < 28; k++) begin
      ch_en[0] = !(k >= 10 && k <= 12);
      ch_en[1] = (k != 5);
      ch_en[2] = !(k >= 5 && k <= 16);
      step_chk(3, k, '0, 1'b0);
    end

    // S4: watchdog vector table, load 10 then 3.
    wt.push_back('{1'b0, 1'b0, 20'd10, 20'd10, 1'b0});
    for (int i = 1; i <= 10; i++) wt.push_back('{1'b1, 1'b0, 20'd10, WDT_W'(10 - i), 1'b0});
    wt.push_back('{1'b1, 1'b0, 20'd10, 20'd0, 1'b1});
    wt.push_back('{1'b1, 1'b0, 20'd10, 20'd0, 1'b1});
    wt.push_back('{1'b1, 1'b1, 20'd10, 20'd10, 1'b0});
    for (int i = 1; i <= 10; i++) wt.push_back('{1'b1, 1'b0, 20'd10, WDT_W'(10 - i), 1'b0});
    wt.push_back('{1'b1, 1'b1, 20'd10, 20'd10, 1'b0});
    wt.push_back('{1'b1, 1'b0, 20'd10, 20'd9, 1'b0});
    wt.push_back('{1'b0, 1'b0, 20'd3, 20'd3, 1'b0});
    for (int i = 1; i <= 3; i++) wt.push_back('{1'b1, 1'b0, 20'd3, WDT_W'(3 - i), 1'b0});
    wt.push_back('{1'b1, 1'b0, 20'd3, 20'd0, 1'b1});
    wt.push_back('{1'b0, 1'b0, 20'd3, 20'd3, 1'b0});
    do_reset();
    clr_tgl();
    for (int i = 0; i < wt.size(); i++) begin
      wdt_en = wt[i].en; wdt_kick = wt[i].kick; wdt_load = wt[i].load;
      step_chk(4, i, wt[i].cnt, wt[i].to);
    end
    wdt_kick = 1'b0;

    // S5: asynchronous reset mid-period, then restart at clk/2 with enables held.
    wdt_en = 1'b0; wdt_load = 20'd2;
    do_reset();
    wr(2'd0, 16'd1); wr(2'd1, 16'd2); wr(2'd2, 16'd3);
    clr_tgl(); set_periodic(0, 1); set_periodic(1, 2); set_periodic(2, 3);
    ch_en = 3'b111; wdt_en = 1'b1;
    for (int k = 0; k < 7; k++) step_chk(5, k, (k < 2) ? WDT_W'(1 - k) : '0, k >= 2);
    #2;
    reset = 1'b0; wdt_en = 1'b0;
    #1;
    cmp("async_rst_clk_tick", 64'({div_clk, tick}), 64'd0);
    cmp("async_rst_wdt", 64'({wdt_count, wdt_timeout}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    clr_tgl(); set_periodic(0, 0); set_periodic(1, 0); set_periodic(2, 0);
    for (int k = 0; k < 8; k++) step_chk(6, k, 20'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
